bcd_timer_core: RTL
===================

# bcd_timer_core

Parametrised BCD stopwatch/timer core with run/pause control, up/down counting, BCD preset load, and a lap-capture buffer. It replaces the fixed 4-digit millisecond counter/FSM pair. It runs on the system clock with an internal tick prescaler instead of a derived clock. Its `count_bcd` output drives the seven-segment display block directly, one nibble per digit.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits; count range 0 to 10^DIGITS−1.
- `TICK_DIV`, 100000: `clk` cycles per count tick (1 ms at 100 MHz); must be ≥2.
- `LAPS`, 4: lap buffer depth; must be ≥1.

Ports:
- `clk`  in  1: system clock. One clock domain; all logic is on the rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: run/pause toggle. Rising edge detected internally; input already synchronised/debounced.
- `clear`  in  1: synchronous clear, level-sensitive, highest priority.
- `mode`  in  2: 00 UP, 01 DOWN, 10 LOAD, 11 HOLD.
- `preset`  in  4·DIGITS: BCD preset, digit 0 in [3:0].
- `lap`  in  1: lap capture. Rising edge detected internally.
- `lap_sel`  in  clog2(LAPS): lap read index.
- `count_bcd`  out  4·DIGITS: current count.
- `lap_bcd`  out  4·DIGITS: lap entry `lap_sel`, registered.
- `lap_count`  out  clog2(LAPS+1): number of stored laps.
- `running`  out  1: state is RUN.
- `expired`  out  1: state is EXPIRED.
- `wrap`  out  1: one-cycle pulse when UP rolls over from all-9s.

## Operation
States: IDLE, RUN, PAUSE, EXPIRED.

State transitions:
- IDLE or PAUSE, start edge → RUN.
- Exception: start edge with mode DOWN and count = 0 → EXPIRED.
- RUN, start edge → PAUSE.
- RUN, DOWN tick with count = 1 (decrements to 0) → EXPIRED.
- EXPIRED exits only via `clear`. Start edges are ignored in EXPIRED.

`clear` (any state):
- count ← 0, state ← IDLE, lap_count ← 0.
- Prescaler ← 0, edge detectors keep sampling.
- Overrides start, lap and LOAD in the same cycle.

LOAD:
- Applies only in IDLE/PAUSE: count ← preset every cycle mode is 10.
- Any preset digit >9 loads as 9.
- Ignored in RUN and EXPIRED.

Ticks:
- Prescaler counts 0..TICK_DIV−1 only in RUN and is held at 0 otherwise.
- A tick fires in the cycle the prescaler is at TICK_DIV−1.
- UP: BCD increment with digit-wise carry. All-9s → all-0s, `wrap` pulses in the same cycle as the update, state stays RUN.
- DOWN: BCD decrement with digit-wise borrow.
- HOLD: tick consumed, count unchanged.
- LOAD in RUN: treated as HOLD.
- A mode change during RUN takes effect at the next tick; the prescaler is not reset.

Lap buffer:
- A lap edge in RUN or PAUSE writes the count value *before* any same-cycle tick update into entry `lap_count`, then increments `lap_count`.
- When `lap_count` = LAPS, further laps are dropped and entries stay unchanged.
- Lap edges in IDLE/EXPIRED are ignored.
- `lap_bcd` shows entry `lap_sel`, or 0 if `lap_sel` ≥ `lap_count`.

## Timing
- Reset values: every output 0, state IDLE, prescaler 0, edge-detector history 0. A held-high `start` or `lap` at reset release therefore produces no edge.
- Start edge: `start` is high in cycle N and was low in N−1. `running` is high from cycle N+1.
- First tick: count changes at the clock edge ending cycle N+TICK_DIV. Subsequent ticks follow every TICK_DIV cycles.
- Pause/resume: pausing mid-period discards the partial prescaler count. After resume, a full TICK_DIV elapses before the next tick.
- Lap edge in cycle M: the entry is written and `lap_count` updates at the end of M. `lap_bcd` reflects it from cycle M+2, one registered read cycle.
- `lap_sel` change: `lap_bcd` updates one cycle later.
- Start edge and tick in the same cycle: the tick applies, then the transition to PAUSE.
- EXPIRED: `expired` rises the cycle after the final decrement, with `count_bcd` = 0.
- Async reset asserted mid-operation: all state returns to reset values immediately. Operation restarts in IDLE on the first edge after release.

## Structure
- Shared package `stopwatch_pkg`:
  - mode encodings MODE_UP/DOWN/LOAD/HOLD,
  - state enum,
  - BCD digit type (4-bit),
  - function `bcd_sat` (clamp a digit to ≤9).
- Sub-module `bcd_digit`, instantiated DIGITS times:
  - inputs: digit, up/down, carry-in, enable;
  - outputs: next digit, carry/borrow-out.
- Prescaler, FSM, edge detectors and lap buffer stay in the top.

## Test plan
Use TICK_DIV=4, DIGITS=4, LAPS=2.
- Reset, UP, start edge at cycle 10 → `running` at 11; count 0001 after cycle 14, 0002 after 18.
- LOAD preset 0x9998 in IDLE, then UP, start → 9999, then 0000 with a one-cycle `wrap` pulse, `running` stays 1.
- LOAD 0x0002, DOWN, start → 0001, 0000, then `expired`=1, `running`=0; a further start edge leaves state EXPIRED; `clear` → IDLE, count 0.
- Three lap edges at counts 0003, 0005, 0007 → `lap_count`=2; `lap_sel`=0 gives 0003, `lap_sel`=1 gives 0005; the third lap is dropped.
- Pause at prescaler=2 for 10 cycles, then resume → the next tick arrives exactly 4 cycles after the resume edge; count has not changed during the pause.
- `clear`, start and lap edges in the same cycle while RUN → count 0, IDLE, `lap_count` 0; `reset_n` pulsed mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch/timer core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_t;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t bcd_sat(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: increment/decrement with ripple carry/borrow.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  bcd_t digit,
  input  logic down,
  input  logic cin,
  input  logic en,
  output bcd_t digit_nx,
  output logic cout
);

  always_comb begin
    digit_nx = digit;
    cout     = 1'b0;
    if (en && cin) begin
      if (down) begin
        if (digit == 4'd0) begin
          digit_nx = 4'd9;
          cout     = 1'b1;
        end else begin
          digit_nx = digit - 4'd1;
        end
      end else begin
        if (digit >= 4'd9) begin
          digit_nx = 4'd0;
          cout     = 1'b1;
        end else begin
          digit_nx = digit + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_timer_core.sv
// BCD stopwatch/timer: run/pause FSM, tick prescaler, up/down/load/hold
// counting and a lap-capture buffer with registered read port.
module bcd_timer_core
  import stopwatch_pkg::*;
#(
  parameter  int unsigned DIGITS   = 4,
  parameter  int unsigned TICK_DIV = 100000,
  parameter  int unsigned LAPS     = 4,
  localparam int unsigned W        = 4 * DIGITS,
  localparam int unsigned SW       = (LAPS > 1) ? $clog2(LAPS) : 1,
  localparam int unsigned CW       = $clog2(LAPS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          clear,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  preset,
  input  logic          lap,
  input  logic [SW-1:0] lap_sel,
  output logic [W-1:0]  count_bcd,
  output logic [W-1:0]  lap_bcd,
  output logic [CW-1:0] lap_count,
  output logic          running,
  output logic          expired,
  output logic          wrap
);

  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  COUNT_ONE  = W'(1);

  state_t        state, state_nx;
  mode_t         mode_e;
  logic [PW-1:0] presc;
  logic          start_q, lap_q;
  logic          start_edge, lap_edge, tick, step_en, lap_wr, wrap_nx;
  logic [W-1:0]  count_nx, count_step, preset_sat, lap_rd;
  logic [DIGITS:0] carry;
  logic [W-1:0]  laps [LAPS];

  assign mode_e     = mode_t'(mode);
  assign start_edge = start & ~start_q;
  assign lap_edge   = lap & ~lap_q;
  assign tick       = (state == ST_RUN) && (presc == PRESC_LAST);
  assign step_en    = tick && ((mode_e == MODE_UP) || (mode_e == MODE_DOWN));
  assign carry[0]   = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit    (count_bcd[4*g +: 4]),
      .down     (mode_e == MODE_DOWN),
      .cin      (carry[g]),
      .en       (step_en),
      .digit_nx (count_step[4*g +: 4]),
      .cout     (carry[g+1])
    );
    assign preset_sat[4*g +: 4] = bcd_sat(preset[4*g +: 4]);
  end

  // Expiry wins over a same-cycle pause request on the final decrement.
  always_comb begin
    state_nx = state;
    count_nx = count_bcd;
    wrap_nx  = 1'b0;
    if (clear) begin
      state_nx = ST_IDLE;
      count_nx = '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_PAUSE: begin
          if (mode_e == MODE_LOAD) count_nx = preset_sat;
          if (start_edge)
            state_nx = ((mode_e == MODE_DOWN) && (count_bcd == '0)) ? ST_EXPIRED : ST_RUN;
        end
        ST_RUN: begin
          if (step_en) count_nx = count_step;
          wrap_nx = step_en && (mode_e == MODE_UP) && carry[DIGITS];
          if (step_en && (mode_e == MODE_DOWN) && (count_bcd == COUNT_ONE))
            state_nx = ST_EXPIRED;
          else if (start_edge)
            state_nx = ST_PAUSE;
        end
        default: ;
      endcase
    end
  end

  assign lap_wr = !clear && lap_edge && ((state == ST_RUN) || (state == ST_PAUSE))
                  && (lap_count < CW'(LAPS));

  always_comb begin
    lap_rd = '0;
    for (int unsigned i = 0; i < LAPS; i++)
      if ((CW'(lap_sel) == CW'(i)) && (CW'(i) < lap_count)) lap_rd = laps[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      count_bcd <= '0;
      presc     <= '0;
      start_q   <= 1'b0;
      lap_q     <= 1'b0;
      wrap      <= 1'b0;
      running   <= 1'b0;
      expired   <= 1'b0;
      lap_count <= '0;
      lap_bcd   <= '0;
      for (int unsigned i = 0; i < LAPS; i++) laps[i] <= '0;
    end else begin
      start_q   <= start;
      lap_q     <= lap;
      state     <= state_nx;
      count_bcd <= count_nx;
      wrap      <= wrap_nx;
      running   <= (state_nx == ST_RUN);
      expired   <= (state_nx == ST_EXPIRED);
      presc     <= ((state == ST_RUN) && (state_nx == ST_RUN) && !tick) ? presc + 1'b1 : '0;
      lap_bcd   <= lap_rd;
      if (clear)
        lap_count <= '0;
      else if (lap_wr)
        lap_count <= lap_count + 1'b1;
      for (int unsigned i = 0; i < LAPS; i++)
        if (lap_wr && (lap_count == CW'(i))) laps[i] <= count_bcd;
    end
  end

endmodule
